// File: rtl/sky130_ef_ip__opamp_ctrl_pkg.sv
// Shared types and default constants for the opamp drive-side controller.
// Optional build macro: OPAMP_CTRL_SYNC_EN.
// It adds a 2-flop comparator synchronizer and 2 lead cycles in MEAS.
package sky130_ef_ip__opamp_ctrl_pkg;

  // Controller state, fixed 2-bit encoding so state values are stable across builds.
  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_SETTLE = 2'd1,
    ST_IDLE   = 2'd2,
    ST_MEAS   = 2'd3
  } opamp_state_t;

  localparam int unsigned SETTLE_CYCLES_DEF = 64;
  localparam int unsigned NSAMP_DEF         = 16;
  localparam int unsigned CW_DEF            = 8;

`ifdef OPAMP_CTRL_SYNC_EN
  // Cycles spent in MEAS before the synchronized comparator value is meaningful.
  localparam int unsigned MEAS_LEAD = 2;
`else
  localparam int unsigned MEAS_LEAD = 0;
`endif

  // Total number of cycles the controller stays in MEAS for one measurement.
  function automatic int unsigned meas_len(input int unsigned nsamp);
    return nsamp + MEAS_LEAD;
  endfunction

endpackage

// File: rtl/sky130_ef_ip__sync2.sv
// Two-flop synchronizer for the asynchronous comparator output.
// Only instantiated when OPAMP_CTRL_SYNC_EN is defined.
module sky130_ef_ip__sync2 (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Shift the input through two flops; cleared only by the block reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/sky130_ef_ip__opamp_ctrl.sv
// Opamp enable / settle / measurement controller.
// Build option: OPAMP_CTRL_SYNC_EN routes cmp_in through a 2-flop synchronizer.
// In that build every measurement takes 2 extra cycles.
// Flow: OFF -> SETTLE (SETTLE_CYCLES) -> IDLE <-> MEAS (count high comparator samples).
// Dropping en_req in any powered state returns to OFF.
module sky130_ef_ip__opamp_ctrl
  import sky130_ef_ip__opamp_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int unsigned NSAMP         = NSAMP_DEF,
  parameter int unsigned CW            = CW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en_req,
  output logic          ena,
  output logic          ready,
  input  logic          start,
  output logic          busy,
  input  logic          cmp_in,
  output logic          valid,
  output logic [CW-1:0] result
);

  localparam int unsigned MEAS_CYCLES = meas_len(NSAMP);
  localparam int unsigned SCW         = $clog2(MEAS_CYCLES + 1);

  opamp_state_t   r_state;
  opamp_state_t   w_state_next;
  logic [15:0]    r_settle_cnt;
  logic [SCW-1:0] r_samp_cnt;
  logic [CW-1:0]  r_acc;
  logic [CW-1:0]  r_result;
  logic           r_valid;

  logic           w_sample;
  logic           w_accum_en;
  logic           w_settle_done;
  logic           w_meas_done;
  logic           w_meas_finish;
  logic [CW-1:0]  w_acc_sum;

`ifdef OPAMP_CTRL_SYNC_EN
  sky130_ef_ip__sync2 u_cmp_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (cmp_in),
    .o_q   (w_sample)
  );
  // The first two MEAS cycles still hold pre-start synchronizer contents.
  assign w_accum_en = (r_samp_cnt >= SCW'(MEAS_LEAD));
`else
  assign w_sample   = cmp_in;
  assign w_accum_en = 1'b1;
`endif

  assign w_settle_done = (r_settle_cnt == 16'(SETTLE_CYCLES - 1));
  assign w_meas_done   = (r_samp_cnt == SCW'(MEAS_CYCLES - 1));
  assign w_acc_sum     = r_acc + {{(CW-1){1'b0}}, w_sample};

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_OFF;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; losing en_req always wins over start or measurement completion.
  always_comb begin
    w_state_next  = r_state;
    w_meas_finish = 1'b0;
    case (r_state)
      ST_OFF: begin
        if (en_req) w_state_next = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (!en_req)            w_state_next = ST_OFF;
        else if (w_settle_done) w_state_next = ST_IDLE;
      end
      ST_IDLE: begin
        // A start arriving in the same cycle as the valid pulse is dropped.
        if (!en_req)                w_state_next = ST_OFF;
        else if (start && !r_valid) w_state_next = ST_MEAS;
      end
      ST_MEAS: begin
        if (!en_req) begin
          w_state_next = ST_OFF;
        end else if (w_meas_done) begin
          w_state_next  = ST_IDLE;
          w_meas_finish = 1'b1;
        end
      end
      default: w_state_next = ST_OFF;
    endcase
  end

  // Settle counter: runs only in SETTLE, so it is zero on every entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_settle_cnt <= '0;
    end else if (r_state == ST_SETTLE) begin
      r_settle_cnt <= r_settle_cnt + 16'd1;
    end else begin
      r_settle_cnt <= '0;
    end
  end

  // Sample counter and accumulator: cleared outside MEAS, advanced every MEAS cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_samp_cnt <= '0;
      r_acc      <= '0;
    end else if (r_state == ST_MEAS) begin
      r_samp_cnt <= r_samp_cnt + SCW'(1);
      if (w_accum_en) r_acc <= w_acc_sum;
    end else begin
      r_samp_cnt <= '0;
      r_acc      <= '0;
    end
  end

  // Result capture and one-cycle valid pulse on a completed measurement only.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_result <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= w_meas_finish;
      if (w_meas_finish) r_result <= w_acc_sum;
    end
  end

  assign ena    = (r_state != ST_OFF);
  assign ready  = (r_state == ST_IDLE) || (r_state == ST_MEAS);
  assign busy   = (r_state == ST_MEAS);
  assign valid  = r_valid;
  assign result = r_result;

endmodule

// File: tb/tb_sky130_ef_ip__opamp_ctrl.sv
// Self-checking bench for sky130_ef_ip__opamp_ctrl.
// Expected values come from timing rules (settle window, start->valid latency)
// and from a popcount of the randomly chosen comparator samples.
module tb_sky130_ef_ip__opamp_ctrl;

  localparam int S  = 64;
  localparam int N  = 16;
  localparam int CW = 8;
`ifdef OPAMP_CTRL_SYNC_EN
  localparam int LAT = N + 3;
`else
  localparam int LAT = N + 1;
`endif
  localparam int BUSY_LEN = LAT - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          en_req;
  logic          start;
  logic          cmp_in;
  logic          ena;
  logic          ready;
  logic          busy;
  logic          valid;
  logic [CW-1:0] result;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_result = 0;
  int n_meas = 0;

  sky130_ef_ip__opamp_ctrl #(
    .SETTLE_CYCLES (S),
    .NSAMP         (N),
    .CW            (CW)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .en_req (en_req),
    .ena    (ena),
    .ready  (ready),
    .start  (start),
    .busy   (busy),
    .cmp_in (cmp_in),
    .valid  (valid),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; outputs are observed 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".ena"},    32'(ena),    0);
    check({tag, ".ready"},  32'(ready),  0);
    check({tag, ".busy"},   32'(busy),   0);
    check({tag, ".valid"},  32'(valid),  0);
    check({tag, ".result"}, 32'(result), 0);
  endtask

  // en_req rises in cycle 0; ena must be high from cycle 1, ready from cycle S+1.
  task automatic power_up(input bit poke_start);
    en_req = 1'b1;
    for (int k = 1; k <= S + 3; k++) begin
      tick();
      start  = 1'b0;
      cmp_in = 1'($urandom_range(0, 1));
      if (poke_start && (k == 10)) start = 1'b1;
      check("pu.ena",   32'(ena),   1);
      check("pu.ready", 32'(ready), (k >= S + 1) ? 1 : 0);
      check("pu.busy",  32'(busy),  0);
      check("pu.valid", 32'(valid), 0);
    end
    $display("power-up: ready after %0d cycles", S);
  endtask

  // One measurement. start is raised in cycle 0, samples bits[t-1] are presented
  // in cycles 1..N. abort_at != 0 drops en_req in that MEAS cycle.
  task automatic measure(input logic [N-1:0] bits, input int abort_at, input bit poke_starts);
    int exp_cnt;
    exp_cnt = $countones(bits);
    start  = 1'b1;
    cmp_in = 1'($urandom_range(0, 1));
    for (int t = 1; t <= LAT + 2; t++) begin
      tick();
      start = 1'b0;
      if ((abort_at != 0) && (t == abort_at + 1)) begin
        check_all_zero_but_result("abort");
        check("abort.result", 32'(result), 32'(exp_result));
        $display("meas %0d: aborted in cycle %0d, result held at %0d", n_meas, abort_at, result);
        n_meas++;
        return;
      end
      cmp_in = (t <= N) ? bits[t-1] : 1'($urandom_range(0, 1));
      check("meas.ena",   32'(ena),   1);
      check("meas.busy",  32'(busy),  (t <= BUSY_LEN) ? 1 : 0);
      check("meas.valid", 32'(valid), (t == LAT) ? 1 : 0);
      if (t < LAT)  check("meas.result_hold", 32'(result), 32'(exp_result));
      if (t >= LAT) check("meas.result", 32'(result), 32'(exp_cnt));
      if (poke_starts && ((t == 3) || (t == LAT))) start = 1'b1;
      if ((abort_at != 0) && (t == abort_at)) en_req = 1'b0;
    end
    start = 1'b0;
    exp_result = exp_cnt;
    $display("meas %0d: bits=%h result=%0d expected=%0d", n_meas, bits, result, exp_cnt);
    n_meas++;
  endtask

  task automatic check_all_zero_but_result(input string tag);
    check({tag, ".ena"},   32'(ena),   0);
    check({tag, ".ready"}, 32'(ready), 0);
    check({tag, ".busy"},  32'(busy),  0);
    check({tag, ".valid"}, 32'(valid), 0);
  endtask

  // Synchronous reset pulse: everything back to zero at the next edge.
  task automatic reset_pulse(input string tag);
    reset = 1'b1;
    tick();
    check_all_zero(tag);
    reset  = 1'b0;
    en_req = 1'b0;
    start  = 1'b0;
    tick();
    check_all_zero({tag, ".off"});
    exp_result = 0;
    $display("reset %s: outputs cleared", tag);
  endtask

  initial begin
    logic [N-1:0] bits;
    reset  = 1'b1;
    en_req = 1'b0;
    start  = 1'b0;
    cmp_in = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    reset = 1'b0;
    tick();
    check_all_zero("off");

    power_up(1'b1);

    measure('1, 0, 1'b0);
    measure(16'h5555, 0, 1'b1);
    measure('0, 0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      bits = N'($urandom);
      measure(bits, 0, (i % 2) == 1);
    end

    // Abort in the 5th MEAS cycle, re-request immediately: full settle again.
    bits = N'($urandom);
    measure(bits, 5, 1'b0);
    power_up(1'b0);
    bits = N'($urandom);
    measure(bits, 0, 1'b1);

    // Reset in the middle of SETTLE.
    en_req = 1'b0;
    tick();
    check_all_zero_but_result("drop");
    en_req = 1'b1;
    repeat (20) tick();
    check("mid_settle.ena", 32'(ena), 1);
    reset_pulse("mid_settle");

    // Reset in the middle of MEAS, after a full-scale result is held.
    power_up(1'b0);
    measure('1, 0, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    check("mid_meas.busy", 32'(busy), 1);
    reset_pulse("mid_meas");

    power_up(1'b0);
    bits = N'($urandom);
    measure(bits, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sky130_ef_ip__opamp_ctrl.md
Name: sky130_ef_ip__opamp_ctrl

Overview:
- Digital controller on the drive side of the analog opamp macro. Generates the opamp's `ena`.
- Times a settling window after power-up, then measures the opamp output. The output is digitized by an external comparator into the 1-bit `cmp_in`; the block counts how many of N samples are high.
- Sits in the dvdd/dvss (1.8V) domain and talks to a digital host through a request/ready and start/valid handshake.

Parameters:
- SETTLE_CYCLES, 64: clock cycles `ena` must be high before `ready` asserts. Legal range 1..65535.
- NSAMP, 16: samples per measurement. Legal range 1..255.
- CW, 8: width of `result`. Must satisfy 2^CW > NSAMP.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- en_req  input  1  host level request to power the opamp
- ena  output  1  opamp enable (active high)
- ready  output  1  opamp settled, measurements allowed
- start  input  1  one-cycle measurement request
- busy  output  1  measurement in progress
- cmp_in  input  1  comparator output (opamp out > threshold)
- valid  output  1  one-cycle pulse, `result` is updated
- result  output  CW  count of high samples in the last measurement

Behaviour:
- Clock and reset: one clock, `clk`. Reset is synchronous and active-high on `reset`.
- Reset values: `ena`=0, `ready`=0, `busy`=0, `valid`=0, `result`=0; FSM in OFF; counters cleared.
- FSM states: OFF, SETTLE, IDLE, MEAS.
- OFF:
  - `ena`=0.
  - `en_req`=1 → SETTLE next cycle, settle counter loaded with 0.
- SETTLE:
  - `ena`=1 and the counter increments each cycle.
  - When count reaches SETTLE_CYCLES-1 → IDLE. `ready` rises SETTLE_CYCLES cycles after `ena` rises.
- IDLE:
  - `ena`=1, `ready`=1.
  - `start`=1 → MEAS with the sample counter and accumulator cleared, `busy`=1 next cycle.
- MEAS:
  - Each cycle samples the (optionally synchronized) `cmp_in` and adds it to the accumulator.
  - After NSAMP samples → IDLE. In that cycle `result` takes the accumulator value and `valid` pulses for one cycle.
  - Latency from `start` to `valid`: NSAMP+1 cycles.
  - `busy` deasserts in the same cycle `valid` pulses.
- `start` handling:
  - Ignored when not in IDLE. No queuing.
  - `start` coincident with the `valid` cycle is ignored; the host re-issues it.
- `en_req` falling:
  - From any non-OFF state → OFF next cycle; `ena`, `ready` and `busy` drop together.
  - A MEAS in progress is aborted: no `valid`, `result` keeps its previous value.
- `en_req` re-rising in the cycle after the drop restarts the full SETTLE window. There is no partial credit.
- Simultaneous `en_req`=0 and `start`=1 in IDLE: the drop wins → OFF.
- Arithmetic: the accumulator is CW bits and cannot overflow (2^CW > NSAMP). `result` holds until the next completed measurement or reset.
- Reset mid-measurement or mid-settle: immediate return to reset values on the next edge.

Optional Feature:
- Macro: OPAMP_CTRL_SYNC_EN.
- Defined:
  - `cmp_in` passes through a 2-flop synchronizer before sampling. The comparator is asynchronous to `clk`.
  - MEAS starts accumulating 2 cycles after entry, so `start`→`valid` latency = NSAMP+3.
  - The synchronizer is cleared by `reset` but not by OFF.
- Undefined: `cmp_in` is sampled directly; latency = NSAMP+1.

Decomposition:
- Shared package sky130_ef_ip__opamp_ctrl_pkg holds:
  - the state typedef (OFF/SETTLE/IDLE/MEAS, 2-bit encoding 0..3);
  - default constants for SETTLE_CYCLES and NSAMP.
- One natural sub-module, sky130_ef_ip__sync2: the 2-flop synchronizer, instantiated only under OPAMP_CTRL_SYNC_EN.
- The FSM, settle counter and accumulator stay in the top module.

Test Plan:
- Power-up timing:
  - Stimulus: reset, then `en_req`=1 at cycle 0, SETTLE_CYCLES=64.
  - Response: `ena`=1 at cycle 1; `ready`=1 at cycle 65; `ready`=0 before that.
- Full-scale measurement:
  - Stimulus: IDLE, `cmp_in` held 1, `start` pulse, NSAMP=16.
  - Response: `busy` for 16 cycles; `valid` pulse; `result`=16. Latency 17, or 19 with SYNC_EN.
- Mixed samples:
  - Stimulus: `cmp_in` toggling 1,0,1,0,… aligned to sampling.
  - Response: `result`=8. A second run with `cmp_in`=0 gives `result`=0.
- Abort:
  - Stimulus: `en_req`=0 during the 5th MEAS cycle.
  - Response: `ena`/`busy`/`ready`=0 next cycle; no `valid`; `result` unchanged.
  - Then `en_req`=1: `ready` returns after a full 64 cycles.
- Ignored starts:
  - Stimulus: `start` pulsed during SETTLE, during MEAS, and in the `valid` cycle.
  - Response: no extra measurement; exactly one `valid` per accepted start.
- Synchronous reset:
  - Stimulus: `reset`=1 mid-SETTLE and mid-MEAS.
  - Response: all outputs 0 at the next edge, OFF state; `result`=0.
